// File: rtl/clock_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clock_period_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic {
        ARM   = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/clock_period_meter_sync_edge_det.sv
// Two-flop synchronizer plus delay register; flags rising/falling edges of the synchronized input.
module sync_edge_det (
    input  logic In_clk,
    input  logic reset,
    input  logic d_i,
    output logic s_o,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge In_clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign s_o    = sync_q;
    assign rise_c = sync_q & ~dly_q;
    assign fall_c = ~sync_q & dly_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period (and high time when CLOCK_PERIOD_METER_DUTY_EN is defined) of a slow
// asynchronous signal in In_clk cycles; results leave through a valid/ready handshake.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEFAULT,
    parameter int unsigned MAX_PERIOD = (2 ** CNT_W) - 1
) (
    input  logic             In_clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic             Meas_in,
    input  logic             Meas_ready,
    output logic             Meas_valid,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] High_time,
    output logic             Overrun,
    output logic             Timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

    logic s;
    logic rise;
    logic fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic cnt_ld;
    logic cnt_clr;
    logic capture;
    logic timeout_evt;
    logic accept;
    logic load;
    logic drop;

    sync_edge_det u_sync (
        .In_clk (In_clk),
        .reset  (reset),
        .d_i    (Meas_in),
        .s_o    (s),
        .rise_c (rise),
        .fall_c (fall)
    );

    always_ff @(posedge In_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // Measurement FSM: cnt_ld restarts a period, cnt_clr parks the counters at zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_ld      = 1'b0;
        cnt_clr     = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        if (!Enable) begin
            state_d = ARM;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) begin
                        state_d = COUNT;
                        cnt_ld  = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                COUNT: begin
                    if (rise) begin
                        capture = 1'b1;
                        cnt_ld  = 1'b1;
                    end else if (cnt_q == MAX_CNT) begin
                        timeout_evt = 1'b1;
                        state_d     = ARM;
                        cnt_clr     = 1'b1;
                    end
                end
                default: begin
                    state_d = ARM;
                    cnt_clr = 1'b1;
                end
            endcase
        end
        if (cnt_ld) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Result handshake: a capture loads only when the slot is empty or being drained.
    always_comb begin
        accept    = valid_q & Meas_ready;
        load      = capture & (~valid_q | Meas_ready);
        drop      = capture & valid_q & ~Meas_ready;
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (load) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            overrun_d = 1'b0;
        end
        if (timeout_evt) begin
            timeout_d = 1'b1;
        end else if (load) begin
            timeout_d = 1'b0;
        end
    end

    assign Meas_valid = valid_q;
    assign Period     = period_q;
    assign Overrun    = overrun_q;
    assign Timeout    = timeout_q;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             hi_run_q, hi_run_d;
    logic             unused_sync;

    always_ff @(posedge In_clk or posedge reset) begin
        if (reset) begin
            hcnt_q   <= '0;
            high_q   <= '0;
            hi_run_q <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            high_q   <= high_d;
            hi_run_q <= hi_run_d;
        end
    end

    // High-time counter; the falling-edge cycle itself is already low, so it is not counted.
    always_comb begin
        hcnt_d   = hcnt_q;
        hi_run_d = hi_run_q;
        high_d   = high_q;
        if (cnt_ld) begin
            hcnt_d   = CNT_W'(1);
            hi_run_d = 1'b1;
        end else if (cnt_clr) begin
            hcnt_d   = '0;
            hi_run_d = 1'b0;
        end else begin
            if (hi_run_q && !fall) begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
            if (fall) begin
                hi_run_d = 1'b0;
            end
        end
        if (load) begin
            high_d = hcnt_q;
        end
    end

    assign High_time   = high_q;
    assign unused_sync = s;
`else
    logic unused_sync;

    assign High_time   = '0;
    assign unused_sync = ^{s, fall};
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: vector table through a scoreboard plus corner sequences.
module tb_clock_period_meter;

    localparam int unsigned CNT_W = 16;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             In_clk;
    logic             reset;
    logic             Enable;
    logic             Meas_in;
    logic             Meas_ready;
    logic             Meas_valid;
    logic [CNT_W-1:0] Period;
    logic [CNT_W-1:0] High_time;
    logic             Overrun;
    logic             Timeout;

    typedef struct {
        int hi;
        int lo;
        int exp_period;
        int exp_high;
    } vec_t;

    typedef struct {
        int period;
        int high;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];
    bit   sb_on;
    int   checks;
    int   errors;

    clock_period_meter #(
        .CNT_W      (CNT_W),
        .MAX_PERIOD (20)
    ) dut (
        .In_clk     (In_clk),
        .reset      (reset),
        .Enable     (Enable),
        .Meas_in    (Meas_in),
        .Meas_ready (Meas_ready),
        .Meas_valid (Meas_valid),
        .Period     (Period),
        .High_time  (High_time),
        .Overrun    (Overrun),
        .Timeout    (Timeout)
    );

    initial In_clk = 1'b0;
    always #5 In_clk = ~In_clk;

    function automatic int exp_hi(input int h);
        return DUTY ? h : 0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge In_clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        Meas_in = 1'b1;
        repeat (hi) tick();
        Meas_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        Meas_in    = 1'b0;
        Meas_ready = 1'b0;
        Enable     = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Scoreboard: every accepted transfer pops one expected result.
    always @(negedge In_clk) begin
        if (sb_on && Meas_valid && Meas_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_period", int'(Period), e.period);
                chk("sb_high_time", int'(High_time), e.high);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   have_pending;
        exp_t pend;
        int   waited;

        checks     = 0;
        errors     = 0;
        sb_on      = 1'b0;
        reset      = 1'b1;
        Enable     = 1'b1;
        Meas_in    = 1'b0;
        Meas_ready = 1'b0;

        vecs[0] = '{hi: 4, lo: 4,  exp_period: 8,  exp_high: 4};
        vecs[1] = '{hi: 4, lo: 4,  exp_period: 8,  exp_high: 4};
        vecs[2] = '{hi: 4, lo: 4,  exp_period: 8,  exp_high: 4};
        vecs[3] = '{hi: 3, lo: 7,  exp_period: 10, exp_high: 3};
        vecs[4] = '{hi: 2, lo: 2,  exp_period: 4,  exp_high: 2};
        vecs[5] = '{hi: 2, lo: 3,  exp_period: 5,  exp_high: 2};
        vecs[6] = '{hi: 6, lo: 10, exp_period: 16, exp_high: 6};
        vecs[7] = '{hi: 9, lo: 2,  exp_period: 11, exp_high: 9};

        // Reset state.
        repeat (3) tick();
        chk("rst_valid", int'(Meas_valid), 0);
        chk("rst_period", int'(Period), 0);
        chk("rst_high", int'(High_time), 0);
        chk("rst_overrun", int'(Overrun), 0);
        chk("rst_timeout", int'(Timeout), 0);
        reset = 1'b0;
        tick();

        // Table vectors, continuous measurement with Meas_ready held high.
        Meas_ready   = 1'b1;
        sb_on        = 1'b1;
        have_pending = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (have_pending) sb_q.push_back(pend);
            pulse(vecs[i].hi, vecs[i].lo);
            pend.period  = vecs[i].exp_period;
            pend.high    = exp_hi(vecs[i].exp_high);
            have_pending = 1'b1;
        end
        sb_q.push_back(pend);
        Meas_in = 1'b1;
        waited  = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        chk("sb_drain", sb_q.size(), 0);
        chk("sb_no_overrun", int'(Overrun), 0);
        sb_on = 1'b0;

        // Handshake stall and overrun.
        do_reset();
        pulse(3, 7);
        pulse(5, 7);
        chk("hs_valid", int'(Meas_valid), 1);
        chk("hs_period", int'(Period), 10);
        chk("hs_high", int'(High_time), exp_hi(3));
        chk("hs_overrun_pre", int'(Overrun), 0);
        Meas_in = 1'b1;
        repeat (3) tick();
        Meas_in = 1'b0;
        tick();
        chk("ovr_flag", int'(Overrun), 1);
        chk("ovr_period_held", int'(Period), 10);
        chk("ovr_high_held", int'(High_time), exp_hi(3));
        Meas_ready = 1'b1;
        tick();
        Meas_ready = 1'b0;
        chk("ovr_accept_valid", int'(Meas_valid), 0);
        chk("ovr_accept_clear", int'(Overrun), 0);

        // Capture coinciding with accept.
        do_reset();
        pulse(3, 7);
        pulse(4, 4);
        chk("sim_first_period", int'(Period), 10);
        Meas_in = 1'b1;
        repeat (2) tick();
        Meas_ready = 1'b1;
        tick();
        Meas_ready = 1'b0;
        chk("sim_valid", int'(Meas_valid), 1);
        chk("sim_period", int'(Period), 8);
        chk("sim_high", int'(High_time), exp_hi(4));
        chk("sim_overrun", int'(Overrun), 0);
        tick();
        chk("sim_valid_hold", int'(Meas_valid), 1);

        // Timeout after a lone edge, then recovery.
        do_reset();
        Meas_in = 1'b1;
        repeat (3) tick();
        Meas_in = 1'b0;
        repeat (19) tick();
        chk("to_not_yet", int'(Timeout), 0);
        tick();
        chk("to_fired", int'(Timeout), 1);
        chk("to_no_valid", int'(Meas_valid), 0);
        pulse(3, 3);
        Meas_in = 1'b1;
        repeat (3) tick();
        chk("to_rec_valid", int'(Meas_valid), 1);
        chk("to_rec_period", int'(Period), 6);
        chk("to_rec_high", int'(High_time), exp_hi(3));
        chk("to_rec_clear", int'(Timeout), 0);

        // Reset mid-measurement while a result is held.
        do_reset();
        pulse(3, 7);
        Meas_in = 1'b1;
        repeat (3) tick();
        chk("mr_valid_pre", int'(Meas_valid), 1);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mr_valid", int'(Meas_valid), 0);
        chk("mr_period", int'(Period), 0);
        chk("mr_high", int'(High_time), 0);
        chk("mr_overrun", int'(Overrun), 0);
        chk("mr_timeout", int'(Timeout), 0);
        Meas_in = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        pulse(4, 4);
        chk("mr_first_edge_only", int'(Meas_valid), 0);
        Meas_in = 1'b1;
        repeat (3) tick();
        chk("mr_second_edge_valid", int'(Meas_valid), 1);
        chk("mr_second_edge_period", int'(Period), 8);

        // Enable gating.
        do_reset();
        pulse(4, 4);
        Meas_in = 1'b1;
        repeat (3) tick();
        chk("en_pre_period", int'(Period), 8);
        repeat (2) tick();
        Enable  = 1'b0;
        Meas_in = 1'b0;
        repeat (2) tick();
        Meas_in = 1'b1;
        repeat (2) tick();
        Meas_ready = 1'b1;
        tick();
        Meas_ready = 1'b0;
        chk("en_off_accept", int'(Meas_valid), 0);
        chk("en_off_no_overrun", int'(Overrun), 0);
        chk("en_off_period_held", int'(Period), 8);
        Enable  = 1'b1;
        Meas_in = 1'b0;
        repeat (3) tick();
        pulse(5, 4);
        chk("en_rearm_no_result", int'(Meas_valid), 0);
        Meas_in = 1'b1;
        repeat (3) tick();
        chk("en_valid", int'(Meas_valid), 1);
        chk("en_period", int'(Period), 9);
        chk("en_high", int'(High_time), exp_hi(5));
        Meas_in = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
